// File: rtl/svc_rv_mem_model.sv
// rtl/svc_rv_mem_model.sv - svc_rv imem/dmem model with byte-valid tracking and 0/1/2-cycle read latency (optional SVC_RV_MEM_MODEL_OOR_EN)
module svc_rv_mem_model #(
  parameter int IMEM_WORDS = 32,
  parameter int DMEM_WORDS = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [32*IMEM_WORDS-1:0] imem_init,
  input  logic                     imem_ren,
  input  logic [31:0]              imem_raddr,
  output logic [31:0]              imem_rdata,
  output logic                     imem_rvalid,
  input  logic                     dmem_ren,
  input  logic [31:0]              dmem_raddr,
  input  logic [31:0]              dmem_free_rdata,
  output logic [31:0]              dmem_rdata,
  output logic                     dmem_rvalid,
  input  logic                     dmem_we,
  input  logic [31:0]              dmem_waddr,
  input  logic [31:0]              dmem_wdata,
  input  logic [3:0]               dmem_wstrb,
  output logic [15:0]              wr_count,
  output logic                     oor_err
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [IAW-1:0] imem_idx;
  logic [DAW-1:0] rd_idx;
  logic [DAW-1:0] wr_idx;

  logic [31:0] mem  [DMEM_WORDS];
  logic [3:0]  mask [DMEM_WORDS];

  logic [31:0] imem_word;
  logic [31:0] dmem_resolved;
  logic [31:0] imem_req_data;
  logic [31:0] dmem_req_data;
  logic        wr_active;

  // Word-offset bits are dropped; high bits only matter to range checking.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_raddr[1:0], dmem_raddr[1:0], dmem_waddr[1:0],
                              imem_raddr[31:IAW+2], dmem_raddr[31:DAW+2], dmem_waddr[31:DAW+2]};

  assign imem_idx  = imem_raddr[IAW+1:2];
  assign rd_idx    = dmem_raddr[DAW+1:2];
  assign wr_idx    = dmem_waddr[DAW+1:2];
  assign wr_active = dmem_we && (dmem_wstrb != 4'b0000);
  assign imem_word = imem_init[{imem_idx, 5'b00000} +: 32];

  // Resolve each read lane to the stored byte or the caller's free byte; idle ports read as zero.
  always_comb begin
    dmem_resolved = dmem_free_rdata;
    for (int b = 0; b < 4; b++) begin
      if (mask[rd_idx][b]) begin
        dmem_resolved[8*b +: 8] = mem[rd_idx][8*b +: 8];
      end
    end
    imem_req_data = imem_ren ? imem_word : 32'h0;
    dmem_req_data = dmem_ren ? dmem_resolved : 32'h0;
  end

  // Byte-lane data array; left uninitialised because the masks hide stale contents.
  always_ff @(posedge clock) begin
    if (wr_active) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_wstrb[b]) begin
          mem[wr_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Byte-valid mask: a lane becomes visible once written and stays so until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mask[i] <= 4'b0000;
      end
    end else if (wr_active) begin
      mask[wr_idx] <= mask[wr_idx] | dmem_wstrb;
    end
  end

  // Saturating count of writes that touched at least one lane.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_count <= 16'h0;
    end else if (wr_active && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'h1;
    end
  end

`ifdef SVC_RV_MEM_MODEL_OOR_EN
  logic oor_hit;
  logic oor_q;

  assign oor_hit = (imem_ren  && (imem_raddr[31:IAW+2] != '0)) ||
                   (dmem_ren  && (dmem_raddr[31:DAW+2] != '0)) ||
                   (wr_active && (dmem_waddr[31:DAW+2] != '0));

  // Sticky flag for any active access whose address exceeds the modelled depth.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oor_q <= 1'b0;
    end else if (oor_hit) begin
      oor_q <= 1'b1;
    end
  end

  assign oor_err = oor_q;
`else
  assign oor_err = 1'b0;
`endif

  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign imem_rdata  = imem_req_data;
      assign imem_rvalid = imem_ren;
      assign dmem_rdata  = dmem_req_data;
      assign dmem_rvalid = dmem_ren;
    end else begin : g_lat_n
      logic [31:0] imem_d1;
      logic        imem_v1;
      logic [31:0] dmem_d1;
      logic        dmem_v1;

      // First read stage captures resolved data, so later writes cannot reach it.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          imem_d1 <= 32'h0;
          imem_v1 <= 1'b0;
          dmem_d1 <= 32'h0;
          dmem_v1 <= 1'b0;
        end else begin
          imem_d1 <= imem_req_data;
          imem_v1 <= imem_ren;
          dmem_d1 <= dmem_req_data;
          dmem_v1 <= dmem_ren;
        end
      end

      if (RD_LATENCY == 1) begin : g_lat1
        assign imem_rdata  = imem_d1;
        assign imem_rvalid = imem_v1;
        assign dmem_rdata  = dmem_d1;
        assign dmem_rvalid = dmem_v1;
      end else begin : g_lat2
        logic [31:0] imem_d2;
        logic        imem_v2;
        logic [31:0] dmem_d2;
        logic        dmem_v2;

        // Second read stage is a plain delay of the first.
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            imem_d2 <= 32'h0;
            imem_v2 <= 1'b0;
            dmem_d2 <= 32'h0;
            dmem_v2 <= 1'b0;
          end else begin
            imem_d2 <= imem_d1;
            imem_v2 <= imem_v1;
            dmem_d2 <= dmem_d1;
            dmem_v2 <= dmem_v1;
          end
        end

        assign imem_rdata  = imem_d2;
        assign imem_rvalid = imem_v2;
        assign dmem_rdata  = dmem_d2;
        assign dmem_rvalid = dmem_v2;
      end
    end
  endgenerate

endmodule

// File: tb/tb_svc_rv_mem_model.sv
// tb/tb_svc_rv_mem_model.sv - directed bench driving latency 0, 1 and 2 instances in lockstep
module tb_svc_rv_mem_model;

  logic           clock = 1'b0;
  logic           reset;
  logic [32*32-1:0] imem_init;
  logic           imem_ren;
  logic [31:0]    imem_raddr;
  logic           dmem_ren;
  logic [31:0]    dmem_raddr;
  logic [31:0]    dmem_free_rdata;
  logic           dmem_we;
  logic [31:0]    dmem_waddr;
  logic [31:0]    dmem_wdata;
  logic [3:0]     dmem_wstrb;

  logic [31:0] i_rdata  [3];
  logic        i_rvalid [3];
  logic [31:0] d_rdata  [3];
  logic        d_rvalid [3];
  logic [15:0] wr_count [3];
  logic        oor_err  [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      svc_rv_mem_model #(.IMEM_WORDS(32), .DMEM_WORDS(32), .RD_LATENCY(g)) u_dut (
        .clock(clock), .reset(reset), .imem_init(imem_init),
        .imem_ren(imem_ren), .imem_raddr(imem_raddr),
        .imem_rdata(i_rdata[g]), .imem_rvalid(i_rvalid[g]),
        .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_free_rdata(dmem_free_rdata),
        .dmem_rdata(d_rdata[g]), .dmem_rvalid(d_rvalid[g]),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .wr_count(wr_count[g]), .oor_err(oor_err[g])
      );
    end
  endgenerate

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_ren = 1'b0; imem_raddr = 32'h0;
    dmem_ren = 1'b0; dmem_raddr = 32'h0; dmem_free_rdata = 32'h0;
    dmem_we = 1'b0; dmem_waddr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
    for (int i = 0; i < 32; i++) imem_init[32*i +: 32] = 32'h1000_0000 + i;
    imem_init[32*5 +: 32] = 32'h00A00093;
    step();
    step();
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (i_rdata[n] !== 32'h0 || i_rvalid[n] !== 1'b0 || d_rdata[n] !== 32'h0 ||
          d_rvalid[n] !== 1'b0 || wr_count[n] !== 16'h0 || oor_err[n] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d got irdata=%h irv=%b drdata=%h drv=%b wc=%h oor=%b want all 0",
                 n, i_rdata[n], i_rvalid[n], d_rdata[n], d_rvalid[n], wr_count[n], oor_err[n]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_imem_read();
    imem_ren = 1'b1; imem_raddr = 32'h14;
    #1;
    checks++;
    if (i_rdata[0] !== 32'h00A00093 || i_rvalid[0] !== 1'b1) begin
      errors++; $display("FAIL imem_lat0 got %h/%b want 00a00093/1", i_rdata[0], i_rvalid[0]);
    end
    step();
    imem_raddr = 32'h0;
    checks++;
    if (i_rdata[1] !== 32'h00A00093 || i_rvalid[1] !== 1'b1) begin
      errors++; $display("FAIL imem_lat1 got %h/%b want 00a00093/1", i_rdata[1], i_rvalid[1]);
    end
    checks++;
    if (i_rvalid[2] !== 1'b0) begin
      errors++; $display("FAIL imem_lat2_early got rvalid=%b want 0", i_rvalid[2]);
    end
    step();
    imem_ren = 1'b0;
    checks++;
    if (i_rdata[2] !== 32'h00A00093 || i_rvalid[2] !== 1'b1) begin
      errors++; $display("FAIL imem_lat2 got %h/%b want 00a00093/1", i_rdata[2], i_rvalid[2]);
    end
    checks++;
    if (i_rdata[1] !== 32'h10000000 || i_rvalid[1] !== 1'b1) begin
      errors++; $display("FAIL imem_word0 got %h/%b want 10000000/1", i_rdata[1], i_rvalid[1]);
    end
    step();
    checks++;
    if (i_rdata[1] !== 32'h0 || i_rvalid[1] !== 1'b0) begin
      errors++; $display("FAIL imem_idle got %h/%b want 0/0", i_rdata[1], i_rvalid[1]);
    end
    step();
  endtask

  task automatic test_dmem_unwritten();
    dmem_ren = 1'b1; dmem_raddr = 32'h8; dmem_free_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (d_rdata[0] !== 32'hDEADBEEF || d_rvalid[0] !== 1'b1) begin
      errors++; $display("FAIL unwritten_lat0 got %h/%b want deadbeef/1", d_rdata[0], d_rvalid[0]);
    end
    step();
    dmem_ren = 1'b0; dmem_free_rdata = 32'h12345678;
    checks++;
    if (d_rdata[1] !== 32'hDEADBEEF || d_rvalid[1] !== 1'b1) begin
      errors++; $display("FAIL unwritten_lat1 got %h/%b want deadbeef/1", d_rdata[1], d_rvalid[1]);
    end
    step();
    checks++;
    if (d_rdata[2] !== 32'hDEADBEEF || d_rvalid[2] !== 1'b1) begin
      errors++; $display("FAIL unwritten_lat2 got %h/%b want deadbeef/1", d_rdata[2], d_rvalid[2]);
    end
    checks++;
    if (d_rdata[1] !== 32'h0 || d_rvalid[1] !== 1'b0) begin
      errors++; $display("FAIL dmem_idle got %h/%b want 0/0", d_rdata[1], d_rvalid[1]);
    end
    step();
  endtask

  task automatic test_partial_write();
    dmem_we = 1'b1; dmem_waddr = 32'h8; dmem_wdata = 32'h11223344; dmem_wstrb = 4'b0101;
    step();
    dmem_wdata = 32'h0; dmem_wstrb = 4'b0000;
    step();
    dmem_we = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (wr_count[n] !== 16'd1) begin
        errors++; $display("FAIL wr_count_partial dut%0d got %0d want 1", n, wr_count[n]);
      end
    end
    dmem_ren = 1'b1; dmem_raddr = 32'h8; dmem_free_rdata = 32'hAABBCCDD;
    #1;
    checks++;
    if (d_rdata[0] !== 32'hAA22CC44) begin
      errors++; $display("FAIL merge_lat0 got %h want aa22cc44", d_rdata[0]);
    end
    step();
    dmem_ren = 1'b0;
    checks++;
    if (d_rdata[1] !== 32'hAA22CC44) begin
      errors++; $display("FAIL merge_lat1 got %h want aa22cc44", d_rdata[1]);
    end
    step();
    checks++;
    if (d_rdata[2] !== 32'hAA22CC44) begin
      errors++; $display("FAIL merge_lat2 got %h want aa22cc44", d_rdata[2]);
    end
    step();
  endtask

  task automatic test_same_cycle();
    dmem_we = 1'b1; dmem_waddr = 32'h8; dmem_wdata = 32'hFFFFFFFF; dmem_wstrb = 4'hF;
    dmem_ren = 1'b1; dmem_raddr = 32'h8; dmem_free_rdata = 32'hAABBCCDD;
    #1;
    checks++;
    if (d_rdata[0] !== 32'hAA22CC44) begin
      errors++; $display("FAIL rf_lat0 got %h want aa22cc44", d_rdata[0]);
    end
    step();
    dmem_we = 1'b0;
    checks++;
    if (d_rdata[1] !== 32'hAA22CC44) begin
      errors++; $display("FAIL rf_lat1 got %h want aa22cc44", d_rdata[1]);
    end
    #1;
    checks++;
    if (d_rdata[0] !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL after_write_lat0 got %h want ffffffff", d_rdata[0]);
    end
    step();
    dmem_ren = 1'b0;
    checks++;
    if (d_rdata[2] !== 32'hAA22CC44 || d_rvalid[2] !== 1'b1) begin
      errors++; $display("FAIL rf_lat2 got %h/%b want aa22cc44/1", d_rdata[2], d_rvalid[2]);
    end
    checks++;
    if (d_rdata[1] !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL after_write_lat1 got %h want ffffffff", d_rdata[1]);
    end
    step();
    checks++;
    if (d_rdata[2] !== 32'hFFFFFFFF || d_rvalid[2] !== 1'b1) begin
      errors++; $display("FAIL after_write_lat2 got %h/%b want ffffffff/1", d_rdata[2], d_rvalid[2]);
    end
    checks++;
    if (wr_count[2] !== 16'd2) begin
      errors++; $display("FAIL wr_count_two got %0d want 2", wr_count[2]);
    end
    step();
  endtask

  task automatic test_reset_inflight();
    dmem_ren = 1'b1; dmem_raddr = 32'h8; dmem_free_rdata = 32'h0;
    imem_ren = 1'b1; imem_raddr = 32'h14;
    step();
    dmem_ren = 1'b0; imem_ren = 1'b0;
    reset = 1'b1;
    #1;
    for (int n = 1; n < 3; n++) begin
      checks++;
      if (d_rvalid[n] !== 1'b0 || i_rvalid[n] !== 1'b0 || d_rdata[n] !== 32'h0 || wr_count[n] !== 16'h0) begin
        errors++;
        $display("FAIL async_reset dut%0d got drv=%b irv=%b drdata=%h wc=%0d want 0/0/0/0",
                 n, d_rvalid[n], i_rvalid[n], d_rdata[n], wr_count[n]);
      end
    end
    #2;
    reset = 1'b0;
    step();
    checks++;
    if (d_rvalid[2] !== 1'b0 || i_rvalid[2] !== 1'b0) begin
      errors++; $display("FAIL discard_inflight got drv=%b irv=%b want 0/0", d_rvalid[2], i_rvalid[2]);
    end
    dmem_ren = 1'b1; dmem_raddr = 32'h8; dmem_free_rdata = 32'h5A5A5A5A;
    #1;
    checks++;
    if (d_rdata[0] !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL post_reset_lat0 got %h want 5a5a5a5a", d_rdata[0]);
    end
    step();
    dmem_ren = 1'b0;
    checks++;
    if (d_rdata[1] !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL post_reset_lat1 got %h want 5a5a5a5a", d_rdata[1]);
    end
    step();
    checks++;
    if (d_rdata[2] !== 32'h5A5A5A5A || wr_count[2] !== 16'h0) begin
      errors++; $display("FAIL post_reset_lat2 got %h wc=%0d want 5a5a5a5a wc=0", d_rdata[2], wr_count[2]);
    end
    step();
  endtask

  task automatic test_oor();
    logic exp_oor;
`ifdef SVC_RV_MEM_MODEL_OOR_EN
    exp_oor = 1'b1;
`else
    exp_oor = 1'b0;
`endif
    checks++;
    if (oor_err[1] !== 1'b0) begin
      errors++; $display("FAIL oor_before got %b want 0", oor_err[1]);
    end
    dmem_we = 1'b1; dmem_waddr = 32'h80; dmem_wdata = 32'hCAFEF00D; dmem_wstrb = 4'hF;
    step();
    dmem_we = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (oor_err[n] !== exp_oor || wr_count[n] !== 16'd1) begin
        errors++; $display("FAIL oor_flag dut%0d got oor=%b wc=%0d want oor=%b wc=1", n, oor_err[n], wr_count[n], exp_oor);
      end
    end
    dmem_ren = 1'b1; dmem_raddr = 32'h0; dmem_free_rdata = 32'h0;
    #1;
    checks++;
    if (d_rdata[0] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL oor_wrap_lat0 got %h want cafef00d", d_rdata[0]);
    end
    step();
    dmem_ren = 1'b0;
    step();
    checks++;
    if (d_rdata[2] !== 32'hCAFEF00D || oor_err[2] !== exp_oor) begin
      errors++; $display("FAIL oor_wrap_lat2 got %h oor=%b want cafef00d oor=%b", d_rdata[2], oor_err[2], exp_oor);
    end
  endtask

  initial begin
    test_reset();
    test_imem_read();
    test_dmem_unwritten();
    test_partial_write();
    test_same_cycle();
    test_reset_inflight();
    test_oor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
